gcd_datapath: RTL and testbench

GCD_DATAPATH -- requirements
Module: gcd_datapath

---
 rtl/gcd_datapath.sv | 134 +++++++++++++
 tb/tb_gcd_datapath.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_datapath.sv
// GCD datapath: holds the A/B operand registers, produces a registered
// compare status for an external controller, applies the controller's
// subtract commands and latches the result when the controller finishes.
// Protocol misuse by the controller is recorded in a sticky error flag.

module gcd_datapath #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [1:0]       sub_AB,
    input  logic             finish,
    output logic [1:0]       A_gr,
    output logic [WIDTH-1:0] gcd_out,
    output logic             gcd_valid,
    output logic             busy,
    output logic             err
);

    // Compare status reported to the controller.
    typedef enum logic [1:0] {
        GR_PENDING = 2'd0,
        GR_DONE    = 2'd1,
        GR_A_GT    = 2'd2,
        GR_B_GT    = 2'd3
    } gr_e;

    // Subtract command issued by the controller.
    typedef enum logic [1:0] {
        SUB_NONE = 2'd0,
        SUB_A    = 2'd1,
        SUB_B    = 2'd2,
        SUB_RSVD = 2'd3
    } sub_e;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] gcd_q, gcd_d;
    gr_e              gr_q, gr_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;

    sub_e             cmd;
    assign cmd = sub_e'(sub_AB);

    // Next-state logic: load, compare, subtract and finish handling.
    always_comb begin
        // NOTE: every _d starts as its _q so no path through the branches
        // below leaves a signal unassigned and infers a latch.
        a_d     = a_q;
        b_d     = b_q;
        gcd_d   = gcd_q;
        gr_d    = gr_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        err_d   = err_q;

        if (!busy_q) begin
            // Idle: only start matters; stray commands and finish are ignored.
            if (start) begin
                a_d     = a_in;
                b_d     = b_in;
                busy_d  = 1'b1;
                valid_d = 1'b0;
                gr_d    = GR_PENDING;
                err_d   = 1'b0;
            end
        end else if (finish) begin
            // Finish wins over any simultaneous subtract, which is discarded.
            gcd_d   = (a_q == '0) ? b_q : a_q;
            valid_d = 1'b1;
            busy_d  = 1'b0;
            gr_d    = GR_PENDING;
            if (gr_q != GR_DONE || cmd != SUB_NONE) begin
                err_d = 1'b1;
            end
        end else if (cmd != SUB_NONE) begin
            // A subtract is only legal when it agrees with the held status.
            if (cmd == SUB_A && gr_q == GR_A_GT) begin
                a_d  = a_q - b_q;
                gr_d = GR_PENDING;
            end else if (cmd == SUB_B && gr_q == GR_B_GT) begin
                b_d  = b_q - a_q;
                gr_d = GR_PENDING;
            end else begin
                err_d = 1'b1;
            end
        end else if (gr_q == GR_PENDING) begin
            // Status is computed once from the registers, then held.
            if (a_q == '0 || b_q == '0) begin
                gr_d = GR_DONE;
            end else if (a_q == b_q) begin
                gr_d = GR_DONE;
            end else if (a_q > b_q) begin
                gr_d = GR_A_GT;
            end else begin
                gr_d = GR_B_GT;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q     <= '0;
            b_q     <= '0;
            gcd_q   <= '0;
            gr_q    <= GR_PENDING;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            a_q     <= a_d;
            b_q     <= b_d;
            gcd_q   <= gcd_d;
            gr_q    <= gr_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign A_gr      = gr_q;
    assign gcd_out   = gcd_q;
    assign gcd_valid = valid_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_gcd_datapath.sv
// Bench for gcd_datapath: a behavioural GCD controller drives the block,
// plus directed standalone command sequences. Expected results come from a
// modulo-based Euclid model pushed to a scoreboard queue at start time.

module tb_gcd_datapath;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic [1:0]   sub_AB = 2'd0;
    logic         finish = 1'b0;
    logic [1:0]   A_gr;
    logic [W-1:0] gcd_out;
    logic         gcd_valid;
    logic         busy;
    logic         err;

    int           n_checks = 0;
    int           n_pass = 0;
    logic [W-1:0] exp_q[$];

    logic [31:0]  seq;
    int           n_sub;
    int           n_adj;

    gcd_datapath #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a_in      (a_in),
        .b_in      (b_in),
        .sub_AB    (sub_AB),
        .finish    (finish),
        .A_gr      (A_gr),
        .gcd_out   (gcd_out),
        .gcd_valid (gcd_valid),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x, y, t;
        x = a;
        y = b;
        while (y != '0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Pulse start for one cycle; returns at the negedge after the load edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        @(negedge clk);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        if (push) exp_q.push_back(ref_gcd(a, b));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Behavioural controller: reacts to A_gr each cycle until it finishes,
    // then compares the result against the scoreboard head.
    task automatic run_ctrl(input bit restart, output logic [31:0] seq_o,
                            output int nsub_o, output int nadj_o);
        logic [1:0] prev;
        bit         done;
        logic [W-1:0] exp_v;
        seq_o  = '0;
        nsub_o = 0;
        nadj_o = 0;
        prev   = 2'd0;
        done   = 1'b0;
        for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
            sub_AB = 2'd0;
            finish = 1'b0;
            start  = 1'b0;
            if (restart && cyc == 1) begin
                start = 1'b1;
                a_in  = 8'd3;
                b_in  = 8'd9;
            end
            case (A_gr)
                2'd1: begin finish = 1'b1; done = 1'b1; end
                2'd2: begin sub_AB = 2'd1; nsub_o++; end
                2'd3: begin sub_AB = 2'd2; nsub_o++; end
                default: ;
            endcase
            if (A_gr != 2'd0) begin
                seq_o = {seq_o[29:0], A_gr};
                if (prev != 2'd0) nadj_o++;
            end
            prev = A_gr;
            @(negedge clk);
        end
        sub_AB = 2'd0;
        finish = 1'b0;
        start  = 1'b0;
        if (!done) begin
            check("ctrl_timeout", 32'd0, 32'd1);
        end else begin
            check("valid_after_finish", gcd_valid, 1);
            check("busy_after_finish", busy, 0);
            check("agr_after_finish", A_gr, 0);
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 32'd0, 32'd1);
            end else begin
                exp_v = exp_q.pop_front();
                check("gcd_out", gcd_out, exp_v);
            end
        end
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_state", {A_gr, gcd_out, gcd_valid, busy, err}, 0);
        @(negedge clk);
        reset = 1'b1;

        // Commands while idle are ignored
        sub_AB = 2'd1;
        finish = 1'b1;
        @(negedge clk);
        sub_AB = 2'd0;
        finish = 1'b0;
        check("idle_cmd_no_err", err, 0);
        check("idle_cmd_state", {gcd_valid, busy, A_gr}, 0);

        // 12,18: status 3,2,1 separated by pending cycles
        start_op(8'd12, 8'd18, 1'b1);
        run_ctrl(1'b0, seq, n_sub, n_adj);
        check("seq_12_18", seq, 32'h39);
        check("adj_12_18", n_adj, 0);
        check("err_12_18", err, 0);

        // 7,7: done immediately, no subtracts
        start_op(8'd7, 8'd7, 1'b1);
        run_ctrl(1'b0, seq, n_sub, n_adj);
        check("seq_7_7", seq, 1);
        check("nsub_7_7", n_sub, 0);

        // Zero operands
        start_op(8'd0, 8'd5, 1'b1);
        run_ctrl(1'b0, seq, n_sub, n_adj);
        check("seq_0_5", seq, 1);
        start_op(8'd0, 8'd0, 1'b1);
        run_ctrl(1'b0, seq, n_sub, n_adj);
        check("seq_0_0", seq, 1);
        check("err_0_0", err, 0);

        // Start re-asserted while busy is ignored
        start_op(8'd12, 8'd18, 1'b1);
        run_ctrl(1'b1, seq, n_sub, n_adj);
        check("restart_seq", seq, 32'h39);

        // Mismatched subtract: no state change, sticky err
        start_op(8'd12, 8'd18, 1'b1);
        @(negedge clk);
        check("sa_agr_b_gt", A_gr, 3);
        sub_AB = 2'd1;
        @(negedge clk);
        sub_AB = 2'd0;
        check("bad_sub_err", err, 1);
        check("bad_sub_agr_held", A_gr, 3);
        run_ctrl(1'b0, seq, n_sub, n_adj);
        check("bad_sub_err_sticky", err, 1);

        // Reserved command, then finish with a simultaneous subtract
        start_op(8'd12, 8'd18, 1'b0);
        check("start_clears_err", err, 0);
        @(negedge clk);
        sub_AB = 2'd3;
        @(negedge clk);
        sub_AB = 2'd0;
        check("rsvd_err", err, 1);
        check("rsvd_agr_held", A_gr, 3);
        finish = 1'b1;
        sub_AB = 2'd2;
        @(negedge clk);
        finish = 1'b0;
        sub_AB = 2'd0;
        check("early_finish_out", gcd_out, 12);
        check("early_finish_flags", {gcd_valid, busy, A_gr, err}, 5'b10001);

        // Finish together with a subtract on an otherwise clean run
        start_op(8'd7, 8'd7, 1'b0);
        @(negedge clk);
        finish = 1'b1;
        sub_AB = 2'd1;
        @(negedge clk);
        finish = 1'b0;
        sub_AB = 2'd0;
        check("fin_sub_err", err, 1);
        check("fin_sub_out", gcd_out, 7);

        // Asynchronous reset after the first subtract
        start_op(8'd12, 8'd18, 1'b1);
        @(negedge clk);
        sub_AB = 2'd2;
        @(negedge clk);
        sub_AB = 2'd0;
        #2;
        reset = 1'b0;
        #1;
        check("async_rst", {A_gr, gcd_out, gcd_valid, busy, err}, 0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        start_op(8'd255, 8'd15, 1'b1);
        run_ctrl(1'b0, seq, n_sub, n_adj);
        check("err_255_15", err, 0);
        check("adj_255_15", n_adj, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
